tt_sweep_gen: RTL and testbench

Exhaustive truth-table sweep engine for a 4-input, 1-output combinational function under test. Sits directly upstream of the function: it drives A, B, C, D through all 16 combinations in ascending order, holds each for a programmable dwell, and samples the returned F. The captured 16-bit truth table is compared against an expected vector, and the engine reports a pass/fail result. This replaces hand-written stimulus sequences with a reusable on-chip sweep.

---
 rtl/tt_sweep_gen_if.sv | 48 ++++
 rtl/tt_sweep_gen.sv | 149 ++++++++++++++
 tb/tb_tt_sweep_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_gen_if.sv
// Bus between the truth-table sweep engine and its environment: control,
// expected vector, stimulus to the function under test, and sweep results.
interface tt_sweep_gen_if;
    logic        start;
    logic [15:0] exp_tt;
    logic        f_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] tt;
    logic [4:0]  mismatch_cnt;

    // Environment side: requests sweeps, supplies expectation and F
    modport master (
        output start,
        output exp_tt,
        output f_in,
        input  a,
        input  b,
        input  c,
        input  d,
        input  busy,
        input  done,
        input  pass,
        input  tt,
        input  mismatch_cnt
    );

    // Engine side
    modport slave (
        input  start,
        input  exp_tt,
        input  f_in,
        output a,
        output b,
        output c,
        output d,
        output busy,
        output done,
        output pass,
        output tt,
        output mismatch_cnt
    );
endinterface

// File: rtl/tt_sweep_gen.sv
// Exhaustive 4-input truth-table sweep: drives {a,b,c,d} = 0..15, holds each
// index for HOLD_CYCLES cycles, samples F on the last cycle of the dwell and
// compares the captured table with exp_tt.
module tt_sweep_gen #(
    parameter int unsigned HOLD_CYCLES = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    tt_sweep_gen_if.slave bus
);

    localparam int unsigned LP_IDX_W   = 4;
    localparam int unsigned LP_DWELL_W = 8;
    localparam int unsigned LP_TT_W    = 16;
    localparam int unsigned LP_CNT_W   = 5;

    localparam logic [LP_DWELL_W-1:0] LP_DWELL_LAST = LP_DWELL_W'(HOLD_CYCLES - 1);
    localparam logic [LP_IDX_W-1:0]   LP_IDX_LAST   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [LP_IDX_W-1:0]   r_idx;
    logic [LP_DWELL_W-1:0] r_dwell;
    logic [LP_TT_W-1:0]    r_tt;
    logic [LP_CNT_W-1:0]   r_cnt;
    logic                  r_pass;
    logic                  r_done;
    logic                  r_busy;
    logic [LP_IDX_W-1:0]   r_abcd;

    state_t                w_state_nxt;
    logic [LP_IDX_W-1:0]   w_idx_nxt;
    logic [LP_DWELL_W-1:0] w_dwell_nxt;
    logic [LP_TT_W-1:0]    w_tt_nxt;
    logic [LP_CNT_W-1:0]   w_cnt_nxt;
    logic                  w_pass_nxt;
    logic                  w_done_nxt;
    logic                  w_busy_nxt;
    logic [LP_IDX_W-1:0]   w_abcd_nxt;

    logic                  w_miss;
    logic [LP_CNT_W-1:0]   w_cnt_inc;
    logic                  w_sample;

    // Mismatch at the current index and the count including it
    assign w_miss    = bus.f_in ^ bus.exp_tt[r_idx];
    assign w_cnt_inc = r_cnt + LP_CNT_W'(w_miss);
    assign w_sample  = (r_dwell == LP_DWELL_LAST);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_dwell <= '0;
            r_tt    <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_abcd  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_dwell <= w_dwell_nxt;
            r_tt    <= w_tt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pass  <= w_pass_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
            r_abcd  <= w_abcd_nxt;
        end
    end

    // Next-state and next-output decode; outputs describe the following cycle
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_dwell_nxt = r_dwell;
        w_tt_nxt    = r_tt;
        w_cnt_nxt   = r_cnt;
        w_pass_nxt  = r_pass;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_abcd_nxt  = r_abcd;

        case (r_state)
            ST_IDLE: begin
                w_abcd_nxt = '0;
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = '0;
                    w_dwell_nxt = '0;
                    w_tt_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end

            ST_RUN: begin
                w_busy_nxt  = 1'b1;
                w_abcd_nxt  = r_idx;
                w_dwell_nxt = r_dwell + LP_DWELL_W'(1);
                if (w_sample) begin
                    w_tt_nxt[r_idx] = bus.f_in;
                    w_cnt_nxt       = w_cnt_inc;
                    w_dwell_nxt     = '0;
                    if (r_idx == LP_IDX_LAST) begin
                        // Last index sampled: publish verdict, pulse done
                        w_state_nxt = ST_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_cnt_inc == '0);
                    end else begin
                        w_idx_nxt  = r_idx + LP_IDX_W'(1);
                        w_abcd_nxt = r_idx + LP_IDX_W'(1);
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_abcd_nxt  = '0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_abcd_nxt  = '0;
            end
        endcase
    end

    assign bus.a            = r_abcd[3];
    assign bus.b            = r_abcd[2];
    assign bus.c            = r_abcd[1];
    assign bus.d            = r_abcd[0];
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.pass         = r_pass;
    assign bus.tt           = r_tt;
    assign bus.mismatch_cnt = r_cnt;

endmodule

// File: tb/tb_tt_sweep_gen.sv
// Bench for tt_sweep_gen: directed and random sweeps compared against a
// table-level model of what the sweep must capture and report.
module tb_tt_sweep_gen;

    localparam int unsigned H = 4;

    logic clk;
    logic rst_n;
    int unsigned n_vec;
    int unsigned n_err;

    tt_sweep_gen_if bus ();

    tt_sweep_gen #(.HOLD_CYCLES(H)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need $finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h need 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] abcd_now();
        return {bus.a, bus.b, bus.c, bus.d};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".abcd"}, 32'(abcd_now()), 32'd0);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".done"}, 32'(bus.done), 32'd0);
        check({tag, ".pass"}, 32'(bus.pass), 32'd0);
        check({tag, ".tt"}, 32'(bus.tt), 32'd0);
        check({tag, ".mis"}, 32'(bus.mismatch_cnt), 32'd0);
    endtask

    // One full sweep, entered at a negedge (the cycle start is sampled) and
    // left at the negedge of the first IDLE cycle. p_idx < 0: F = fn(a..d);
    // otherwise F is a one-cycle pulse at (p_idx, p_dw) of the bench timeline.
    task automatic run_sweep(input logic [15:0] fn, input logic [15:0] ex,
                             input int p_idx, input int p_dw,
                             input bit keep_start, input bit start_in_done);
        logic [15:0] m_tt;
        int          m_mis;
        int          n_run;
        n_run = 16 * int'(H);
        if (p_idx < 0) begin
            m_tt = fn;
        end else begin
            m_tt = '0;
            if (p_dw == int'(H) - 1) m_tt[p_idx] = 1'b1;
        end
        m_mis = $countones(m_tt ^ ex);

        bus.exp_tt = ex;
        bus.start  = 1'b1;
        bus.f_in   = 1'b0;
        for (int k = 1; k <= n_run; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = keep_start;
            check("run.abcd", 32'(abcd_now()), 32'((k - 1) / int'(H)));
            check("run.busy", 32'(bus.busy), 32'd1);
            check("run.done", 32'(bus.done), 32'd0);
            if (p_idx < 0)
                bus.f_in = fn[abcd_now()];
            else
                bus.f_in = (((k - 1) / int'(H)) == p_idx) && (((k - 1) % int'(H)) == p_dw);
        end

        @(negedge clk);
        bus.f_in = 1'b0;
        check("done.done", 32'(bus.done), 32'd1);
        check("done.busy", 32'(bus.busy), 32'd0);
        check("done.abcd", 32'(abcd_now()), 32'd15);
        check("done.tt", 32'(bus.tt), 32'(m_tt));
        check("done.mis", 32'(bus.mismatch_cnt), 32'(m_mis));
        check("done.pass", 32'(bus.pass), 32'(m_mis == 0));
        if (start_in_done) bus.start = 1'b1;

        @(negedge clk);
        if (start_in_done) bus.start = 1'b0;
        check("idle.done", 32'(bus.done), 32'd0);
        check("idle.busy", 32'(bus.busy), 32'd0);
        check("idle.abcd", 32'(abcd_now()), 32'd0);
        check("idle.tt", 32'(bus.tt), 32'(m_tt));
        check("idle.mis", 32'(bus.mismatch_cnt), 32'(m_mis));
        check("idle.pass", 32'(bus.pass), 32'(m_mis == 0));
    endtask

    initial begin
        logic [15:0] fn;
        logic [15:0] ex;
        n_vec = 0;
        n_err = 0;

        // Reset held with start high
        rst_n      = 1'b0;
        bus.start  = 1'b1;
        bus.exp_tt = 16'h0;
        bus.f_in   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst.busy", 32'(bus.busy), 32'd0);
        end

        // Parity function: pass, single mismatch, all mismatch
        run_sweep(16'h6996, 16'h6996, -1, 0, 1'b0, 1'b0);
        run_sweep(16'h6996, 16'h6997, -1, 0, 1'b0, 1'b0);
        run_sweep(16'h6996, 16'h9669, -1, 0, 1'b0, 1'b0);

        // Start held across a sweep re-arms exactly once after IDLE
        run_sweep(16'h6996, 16'h6996, -1, 0, 1'b1, 1'b0);
        run_sweep(16'hA5C3, 16'hA5C3, -1, 0, 1'b0, 1'b0);

        // Start only during DONE is dropped
        run_sweep(16'h1234, 16'h1235, -1, 0, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("done_start.busy", 32'(bus.busy), 32'd0);
            check("done_start.abcd", 32'(abcd_now()), 32'd0);
        end

        // Sample point: only the last dwell cycle of an index is captured
        run_sweep(16'h0, 16'h0020, 5, int'(H) - 1, 1'b0, 1'b0);
        run_sweep(16'h0, 16'h0020, 5, int'($urandom_range(H - 2, 0)), 1'b0, 1'b0);
        run_sweep(16'h0, 16'h0000, 5, 0, 1'b0, 1'b0);

        // Reset in the middle of index 7
        fn         = 16'($urandom);
        bus.exp_tt = fn;
        bus.start  = 1'b1;
        for (int k = 1; k <= 7 * int'(H) + 2; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            bus.f_in = fn[abcd_now()];
        end
        check("mid.abcd", 32'(abcd_now()), 32'd7);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_rst");
        repeat (3) begin
            @(negedge clk);
            check("mid_rst.done", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rel");
        run_sweep(fn, fn, -1, 0, 1'b0, 1'b0);

        // Random functions and expectations
        for (int r = 0; r < 6; r++) begin
            fn = 16'($urandom);
            case (r % 3)
                0:       ex = fn;
                1:       ex = fn ^ (16'h1 << $urandom_range(15, 0));
                default: ex = 16'($urandom);
            endcase
            run_sweep(fn, ex, -1, 0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
